// File: rtl/xbar_cfg_loader_if.sv
// ---------------------------------------------------------------------------
// xbar_cfg_loader_if
// Handshake and status bundle between a configuration source and the
// crossbar configuration loader.
//   io_cfg_start   : one-cycle pulse that begins a frame (source -> loader)
//   io_cfg_valid   : stream word valid (source -> loader)
//   io_cfg_data    : stream word (source -> loader)
//   io_cfg_ready   : loader accepts a word this cycle (loader -> source)
//   io_busy        : loader is processing a frame
//   io_done        : one-cycle end-of-frame pulse (success or error)
//   io_err         : last frame failed, sticky until the next start
//   io_err_code    : 00 none, 01 checksum mismatch, 10 select out of range
//   io_mux_configs : active crossbar configuration
// The master modport is the configuration source, slave is the loader.
// ---------------------------------------------------------------------------
interface xbar_cfg_loader_if #(
   parameter int WORD_WIDTH = 8,
   parameter int CFG_WIDTH  = 120
);
   logic                  io_cfg_start;
   logic                  io_cfg_valid;
   logic [WORD_WIDTH-1:0] io_cfg_data;
   logic                  io_cfg_ready;
   logic                  io_busy;
   logic                  io_done;
   logic                  io_err;
   logic [1:0]            io_err_code;
   logic [CFG_WIDTH-1:0]  io_mux_configs;

   modport master (
      output io_cfg_start, io_cfg_valid, io_cfg_data,
      input  io_cfg_ready, io_busy, io_done, io_err, io_err_code, io_mux_configs
   );

   modport slave (
      input  io_cfg_start, io_cfg_valid, io_cfg_data,
      output io_cfg_ready, io_busy, io_done, io_err, io_err_code, io_mux_configs
   );
endinterface

// File: rtl/xbar_cfg_loader.sv
// ---------------------------------------------------------------------------
// xbar_cfg_loader
// Configuration front end for the LUT-tile crossbar. A framed byte stream
// (NUM_WORDS data words, least-significant first, then one XOR checksum
// word) is collected into a shadow register. After the checksum matches,
// every select field is range-checked one per cycle; only a fully valid
// frame is copied to the active io_mux_configs register, so the crossbar
// never sees a partial or illegal configuration.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears everything including the
//           active configuration
//   cfg   : xbar_cfg_loader_if.slave (stream handshake, status, config bus)
// ---------------------------------------------------------------------------
module xbar_cfg_loader #(
   parameter int CFG_WIDTH   = 120,
   parameter int NUM_OUTPUTS = 24,
   parameter int SEL_WIDTH   = 5,
   parameter int XBAR_INPUTS = 19,
   parameter int WORD_WIDTH  = 8
) (
   input  logic             clk,
   input  logic             reset,
   xbar_cfg_loader_if.slave cfg
);
   localparam int NUM_WORDS = CFG_WIDTH / WORD_WIDTH;
   localparam int WCNT_W    = $clog2(NUM_WORDS + 1);
   localparam int FCNT_W    = $clog2(NUM_OUTPUTS);

   typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

   state_t                state, state_next;
   logic [WCNT_W-1:0]     word_cnt;
   logic [FCNT_W-1:0]     field_cnt;
   logic [CFG_WIDTH-1:0]  shadow;
   logic [CFG_WIDTH-1:0]  active_cfg;
   logic [WORD_WIDTH-1:0] xor_acc;
   logic                  err;
   logic [1:0]            err_code;
   logic                  done, done_next;
   logic                  start, xfer, last_word, cks_ok, last_field, sel_bad;
   logic [SEL_WIDTH-1:0]  cur_sel;

   // Select field idx of a packed configuration vector.
   function automatic logic [SEL_WIDTH-1:0] field_at(input logic [CFG_WIDTH-1:0] v,
                                                     input logic [FCNT_W-1:0]    idx);
      logic [SEL_WIDTH-1:0] r;
      r = '0;
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
         if (idx == FCNT_W'(k)) r = v[k*SEL_WIDTH +: SEL_WIDTH];
      end
      return r;
   endfunction

   assign start      = cfg.io_cfg_start;
   // A start pulse has priority, so no word is taken in the start cycle.
   assign cfg.io_cfg_ready = (state == LOAD) && !start;
   assign xfer       = cfg.io_cfg_valid && cfg.io_cfg_ready;
   // word_cnt == NUM_WORDS means the current transfer is the checksum word.
   assign last_word  = (word_cnt == WCNT_W'(NUM_WORDS));
   assign cks_ok     = (cfg.io_cfg_data == xor_acc);
   assign last_field = (field_cnt == FCNT_W'(NUM_OUTPUTS - 1));
   assign cur_sel    = field_at(shadow, field_cnt);
   assign sel_bad    = (cur_sel >= SEL_WIDTH'(XBAR_INPUTS));

   assign cfg.io_busy        = (state != IDLE);
   assign cfg.io_done        = done;
   assign cfg.io_err         = err;
   assign cfg.io_err_code    = err_code;
   assign cfg.io_mux_configs = active_cfg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      if (start) begin
         // Abort (or begin) silently: no done pulse for an aborted frame.
         state_next = LOAD;
      end else begin
         case (state)
            IDLE: state_next = IDLE;
            LOAD: begin
               if (xfer && last_word) begin
                  state_next = cks_ok ? CHECK : IDLE;
                  done_next  = !cks_ok;
               end
            end
            CHECK: begin
               if (sel_bad) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else if (last_field) begin
                  state_next = COMMIT;
               end
            end
            COMMIT: begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_cnt   <= '0;
         field_cnt  <= '0;
         shadow     <= '0;
         active_cfg <= '0;
         xor_acc    <= '0;
         err        <= 1'b0;
         err_code   <= 2'b00;
         done       <= 1'b0;
      end else begin
         done <= done_next;
         if (start) begin
            word_cnt  <= '0;
            field_cnt <= '0;
            shadow    <= '0;
            xor_acc   <= '0;
            err       <= 1'b0;
            err_code  <= 2'b00;
         end else begin
            case (state)
               LOAD: begin
                  if (xfer) begin
                     if (last_word) begin
                        field_cnt <= '0;
                        if (!cks_ok) begin
                           err      <= 1'b1;
                           err_code <= 2'b01;
                        end
                     end else begin
                        for (int n = 0; n < NUM_WORDS; n++) begin
                           if (word_cnt == WCNT_W'(n))
                              shadow[n*WORD_WIDTH +: WORD_WIDTH] <= cfg.io_cfg_data;
                        end
                        xor_acc  <= xor_acc ^ cfg.io_cfg_data;
                        word_cnt <= word_cnt + 1'b1;
                     end
                  end
               end
               CHECK: begin
                  if (sel_bad) begin
                     err      <= 1'b1;
                     err_code <= 2'b10;
                  end else begin
                     field_cnt <= field_cnt + 1'b1;
                  end
               end
               COMMIT: active_cfg <= shadow;
               default: ;
            endcase
         end
      end
   end
endmodule

// File: doc/xbar_cfg_loader.md
# xbar_cfg_loader

Configuration front end for the LUT-tile crossbar. It accepts a framed byte stream over a valid/ready handshake and verifies its XOR checksum. It then range-checks every select field sequentially and only then commits the frame to the registered `io_mux_configs` bus that drives the crossbar. The crossbar never sees a partially loaded or invalid configuration.

## Interface
- `CFG_WIDTH`, 120: total select bits; equals `NUM_OUTPUTS*SEL_WIDTH`.
- `NUM_OUTPUTS`, 24: number of crossbar outputs (select fields).
- `SEL_WIDTH`, 5: bits per select field.
- `XBAR_INPUTS`, 19: legal select values are 0..`XBAR_INPUTS-1`.
- `WORD_WIDTH`, 8: stream word width; `CFG_WIDTH` is a multiple of it; `NUM_WORDS = CFG_WIDTH/WORD_WIDTH` (15).
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `io_cfg_start`, in, 1: one-cycle pulse that begins a frame.
- `io_cfg_valid`, in, 1: stream word valid.
- `io_cfg_data`, in, `WORD_WIDTH`: stream word.
- `io_cfg_ready`, out, 1: loader accepts a word this cycle.
- `io_busy`, out, 1: state is not IDLE.
- `io_done`, out, 1: one-cycle pulse marking the end of a frame, on success or error.
- `io_err`, out, 1: the last frame failed; sticky until the next `io_cfg_start`.
- `io_err_code`, out, 2: 00 none, 01 checksum mismatch, 10 select out of range.
- `io_mux_configs`, out, `CFG_WIDTH`: active configuration; field k = bits [5k+4:5k].

## Operation
- **States:**
  - **IDLE:** waits for `io_cfg_start`.
  - **LOAD:** accepts `NUM_WORDS` data words plus one checksum word.
  - **CHECK:** scans one field per cycle.
  - **COMMIT:** copies the shadow register to the active register.
- **Reset:** all outputs are 0 (so every crossbar output selects input 0), state is IDLE, and the shadow register and counters are cleared.
- **Start:**
  - `io_cfg_start` in any state moves to LOAD.
  - It clears the word counter, shadow register, running XOR, `io_err` and `io_err_code`.
  - A start in LOAD or CHECK aborts the current frame with no error and no `io_done`.
  - `io_mux_configs` is unchanged.
- **Ready:** `io_cfg_ready = (state==LOAD) && !io_cfg_start`. A word transfers when `io_cfg_valid && io_cfg_ready`. Gaps in valid are allowed in any number.
- **Data words:** word n (0..14) is written to shadow bits [8n+7:8n], least-significant word first, and is XORed into the running checksum.
- **Checksum word (16th transfer):**
  - If it equals the running XOR of words 0..14, go to CHECK with the field counter at 0.
  - Otherwise go to IDLE with `io_err=1` and code 01.
- **CHECK:**
  - Each cycle, test field f = counter. If it is ≥ `XBAR_INPUTS`, go to IDLE with `io_err=1` and code 10; the remaining fields are not scanned.
  - Otherwise increment the counter. After field 23 passes, go to COMMIT.
- **COMMIT (one cycle):** load `io_mux_configs` from the shadow register, then go to IDLE.
- **Done:** `io_done` is registered and high for exactly one cycle, the first cycle in IDLE after COMMIT or after an error exit. On error, `io_mux_configs` keeps its previous value.
- **Ignored inputs:** valid or data outside LOAD are ignored, and so are words beyond the 16th (ready is already low).

## Timing
- Cycle t is the checksum transfer.
- **Success:** CHECK occupies t+1..t+24 and COMMIT is t+25. New `io_mux_configs` and `io_done=1` are both visible in cycle t+26, with `io_busy=0`.
- **Checksum error:** `io_err`, code 01 and `io_done` are visible at t+1.
- **Range error:** a bad field f is examined at t+1+f. Error outputs and `io_done` are visible at t+2+f.
- **Minimum frame:** 16 transfers with no gaps, so at most 42 cycles from the start pulse to `io_done`.
- `io_busy` is high from the cycle after `io_cfg_start` until the IDLE cycle.
- **Asynchronous reset** at any point, including mid-CHECK or mid-COMMIT:
  - It returns immediately to the reset values above.
  - `io_mux_configs` becomes 0, not the previous value.

## Test plan
- **Reset values:** assert reset mid-stream → all outputs 0, `io_cfg_ready=0`, `io_busy=0`.
- **Good frame:** field k = k mod 19, correct XOR, no gaps → exactly 16 ready handshakes; `io_mux_configs` updates and `io_done=1` 26 cycles after the checksum transfer; `io_err=0`; field 19 reads 0 and field 23 reads 4.
- **Bad checksum:** the same frame with the checksum XOR 0x01 → `io_err=1` and code 01 one cycle after the checksum; `io_done` pulses once; `io_mux_configs` holds the prior frame.
- **Out-of-range field:** field 7 = 19 with a correct checksum → error at checksum+9 with code 10; configs unchanged. Repeat with field 7 = 31 → same result.
- **Restart and backpressure:** start, 5 words, start again, then a full good frame with random valid gaps → only the second frame commits; no `io_done` for the aborted frame; `io_cfg_start` with valid in the same cycle transfers no word.
- **Reset mid-CHECK:** assert reset at checksum+10 → `io_mux_configs=0`, state IDLE, no `io_done`; a following good frame loads normally.
